// File: rtl/sequenciador_proximidade.sv
// sequenciador_proximidade
// Shares one ultrasonic measurement interface between the left and right
// sensors. Each cycle triggers the left sensor, waits for its result (or a
// timeout), stores it, then does the same for the right sensor. It signals
// the end of the cycle and restarts INTERVALO clocks after the previous
// left trigger, for as long as ligar stays high.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high
//   ligar       enable; low sends the sequencer back to INICIAL
//   medir       one-clock trigger pulse to the measurement interface
//   sel_sensor  interface routing: 0 = left, 1 = right
//   pronto      interface result-valid pulse
//   medida      interface result, valid while pronto = 1
//   medida_esq  last stored left result (all ones after a timeout)
//   medida_dir  last stored right result (all ones after a timeout)
//   esq, dir    obstacle flags (stored result < LIMIAR)
//   erro_esq    left sensor timed out on its last attempt
//   erro_dir    right sensor timed out on its last attempt
//   fim_ciclo   one-clock pulse once both sides are stored
//   db_estado   current state code, for debug
module sequenciador_proximidade #(
    parameter int N         = 12,
    parameter int LIMIAR    = 10,
    parameter int INTERVALO = 2500000,
    parameter int TIMEOUT   = 1500000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ligar,
    output logic         medir,
    output logic         sel_sensor,
    input  logic         pronto,
    input  logic [N-1:0] medida,
    output logic [N-1:0] medida_esq,
    output logic [N-1:0] medida_dir,
    output logic         esq,
    output logic         dir,
    output logic         erro_esq,
    output logic         erro_dir,
    output logic         fim_ciclo,
    output logic [3:0]   db_estado
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int INT_W = (INTERVALO > 2) ? $clog2(INTERVALO) : 1;

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        DISPARA_ESQ  = 4'd1,
        AGUARDA_ESQ  = 4'd2,
        ARMAZENA_ESQ = 4'd3,
        TIMEOUT_ESQ  = 4'd4,
        DISPARA_DIR  = 4'd5,
        AGUARDA_DIR  = 4'd6,
        ARMAZENA_DIR = 4'd7,
        TIMEOUT_DIR  = 4'd8,
        FIM          = 4'd9,
        ESPERA       = 4'd10
    } estado_t;

    estado_t          estado, prox;
    logic [TMO_W-1:0] cnt_tmo;
    logic [INT_W-1:0] cnt_int;
    logic [N-1:0]     medida_cap;
    logic             tmo_fim, int_fim;

    // Unsigned compare; a result equal to the threshold is not an obstacle.
    function automatic logic proximo(input logic [N-1:0] valor);
        return valor < N'(LIMIAR);
    endfunction

    assign tmo_fim   = (cnt_tmo == TMO_W'(TIMEOUT - 1));
    assign int_fim   = (cnt_int >= INT_W'(INTERVALO - 1));
    assign db_estado = estado;

    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= prox;
    end

    always_comb begin
        prox       = estado;
        medir      = 1'b0;
        fim_ciclo  = 1'b0;
        sel_sensor = 1'b0;
        case (estado)
            INICIAL:      prox = DISPARA_ESQ;
            DISPARA_ESQ:  begin
                medir = 1'b1;
                prox  = AGUARDA_ESQ;
            end
            // pronto takes priority over a timeout landing on the same clock
            AGUARDA_ESQ:  begin
                if (pronto)       prox = ARMAZENA_ESQ;
                else if (tmo_fim) prox = TIMEOUT_ESQ;
            end
            ARMAZENA_ESQ,
            TIMEOUT_ESQ:  prox = DISPARA_DIR;
            DISPARA_DIR:  begin
                medir      = 1'b1;
                sel_sensor = 1'b1;
                prox       = AGUARDA_DIR;
            end
            AGUARDA_DIR:  begin
                sel_sensor = 1'b1;
                if (pronto)       prox = ARMAZENA_DIR;
                else if (tmo_fim) prox = TIMEOUT_DIR;
            end
            ARMAZENA_DIR,
            TIMEOUT_DIR:  begin
                sel_sensor = 1'b1;
                prox       = FIM;
            end
            FIM:          begin
                fim_ciclo = 1'b1;
                prox      = ESPERA;
            end
            ESPERA:       if (int_fim) prox = DISPARA_ESQ;
            default:      prox = INICIAL;
        endcase
        // Disabling wins over every transition and silences the pulses.
        if (!ligar) begin
            prox      = INICIAL;
            medir     = 1'b0;
            fim_ciclo = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_tmo    <= '0;
            cnt_int    <= '0;
            medida_cap <= '0;
            medida_esq <= '0;
            medida_dir <= '0;
            esq        <= 1'b0;
            dir        <= 1'b0;
            erro_esq   <= 1'b0;
            erro_dir   <= 1'b0;
        end else begin
            // The trigger clock is the first clock of the interval, so the
            // next trigger lands exactly INTERVALO clocks later. Saturates.
            if (ligar && estado == DISPARA_ESQ) cnt_int <= INT_W'(1);
            else if (!int_fim)                  cnt_int <= cnt_int + INT_W'(1);

            if (ligar) begin
                case (estado)
                    DISPARA_ESQ, DISPARA_DIR: cnt_tmo <= '0;
                    AGUARDA_ESQ, AGUARDA_DIR: begin
                        cnt_tmo <= cnt_tmo + TMO_W'(1);
                        if (pronto) medida_cap <= medida;
                    end
                    ARMAZENA_ESQ: begin
                        medida_esq <= medida_cap;
                        esq        <= proximo(medida_cap);
                        erro_esq   <= 1'b0;
                    end
                    TIMEOUT_ESQ: begin
                        medida_esq <= '1;
                        esq        <= 1'b0;
                        erro_esq   <= 1'b1;
                    end
                    ARMAZENA_DIR: begin
                        medida_dir <= medida_cap;
                        dir        <= proximo(medida_cap);
                        erro_dir   <= 1'b0;
                    end
                    TIMEOUT_DIR: begin
                        medida_dir <= '1;
                        dir        <= 1'b0;
                        erro_dir   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/sequenciador_proximidade.md
Name: sequenciador_proximidade

Overview:
- Schedules one shared ultrasonic measurement interface between the left and right sensors.
- Each cycle it triggers left then right, waits for each result, latches it, and raises registered proximity flags (measurement < LIMIAR) for the vehicle control FSM.
- Repeats every INTERVALO clocks while enabled.
- Flags each sensor that fails to answer within TIMEOUT.

Parameters:
- N, 12, measurement width (bits).
- LIMIAR, 10, proximity threshold; flag set when medida < LIMIAR, unsigned compare.
- INTERVALO, 2500000, clocks between consecutive cycle starts (50 ms at 50 MHz).
- TIMEOUT, 1500000, max clocks waiting for pronto after a trigger.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- ligar  in  1  enable; while low the block idles.
- medir  out  1  one-clock trigger pulse to the measurement interface.
- sel_sensor  out  1  routes the interface: 0=left, 1=right; stable from trigger until store.
- pronto  in  1  interface result-valid pulse.
- medida  in  N  interface result, valid when pronto=1.
- medida_esq  out  N  last latched left result.
- medida_dir  out  N  last latched right result.
- esq  out  1  left obstacle flag.
- dir  out  1  right obstacle flag.
- erro_esq  out  1  left sensor timed out in last attempt.
- erro_dir  out  1  right sensor timed out in last attempt.
- fim_ciclo  out  1  one-clock pulse after both sides stored.
- db_estado  out  4  current state code, for debug.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high, sampled on the rising edge of clock, and has priority over everything.
  - Reset values: state INICIAL; medida_esq/medida_dir = 0; esq, dir, erro_esq, erro_dir, medir, fim_ciclo, sel_sensor = 0; all counters = 0.
- States (db_estado codes):
  - INICIAL 0: wait for ligar=1, then go to DISPARA_ESQ.
  - DISPARA_ESQ 1: medir=1 for exactly this cycle, sel_sensor=0. Clear timeout counter; clear interval counter (cycle start). Next: AGUARDA_ESQ.
  - AGUARDA_ESQ 2: timeout counter increments.
    - pronto=1 → ARMAZENA_ESQ.
    - Otherwise, when timeout count reaches TIMEOUT-1 → TIMEOUT_ESQ.
    - pronto wins if both occur in the same cycle.
  - ARMAZENA_ESQ 3:
    - medida_esq <= medida captured in the cycle pronto was high.
    - esq <= (captured < LIMIAR); erro_esq <= 0.
    - Next: DISPARA_DIR.
  - TIMEOUT_ESQ 4: medida_esq <= all ones; esq <= 0; erro_esq <= 1. Next: DISPARA_DIR.
  - DISPARA_DIR 5, AGUARDA_DIR 6, ARMAZENA_DIR 7, TIMEOUT_DIR 8:
    - Mirror the left-side states with sel_sensor=1 and the right-side registers.
    - Exit of ARMAZENA_DIR/TIMEOUT_DIR: FIM 9.
  - FIM 9: fim_ciclo=1 for this cycle. Next: ESPERA 10.
  - ESPERA 10:
    - When interval count ≥ INTERVALO-1 → DISPARA_ESQ.
    - If the interval already expired during measurement, leave ESPERA on the next clock; no cycle is skipped.
- Capture and latency:
  - medida is captured into an internal register on the pronto cycle.
  - Outputs update at the end of ARMAZENA; flags are visible 2 clocks after the pronto cycle.
- Outputs between updates:
  - medida_x, esq/dir and erro_x hold their values between updates.
  - They are registered, never combinational from medida.
- Interval counter:
  - Free-runs from DISPARA_ESQ and saturates at INTERVALO-1; no wrap.
- pronto outside AGUARDA_ESQ/AGUARDA_DIR is ignored, including a late pronto after a timeout.
- ligar deasserted in any non-INICIAL state:
  - Return to INICIAL on the next clock.
  - medir and fim_ciclo are forced 0; latched results and flags hold.
  - Re-enabling starts a fresh cycle at DISPARA_ESQ.
- Reset mid-measurement: immediate return to reset values; the interface may still emit pronto, which is ignored.
- Compare rule: equality (medida == LIMIAR) is not proximity.

Test Plan:
- Bench parameters: N=12, LIMIAR=10, INTERVALO=100, TIMEOUT=40.
- Basic cycle: ligar=1; left pronto 5 clocks after trigger with medida=7, right pronto 8 clocks after trigger with medida=25.
  - Required: medir pulses at sel 0 then sel 1.
  - medida_esq=7, esq=1; medida_dir=25, dir=0.
  - fim_ciclo pulses once; next left trigger exactly 100 clocks after the first.
- Boundary: medida=10 left, 9 right → esq=0, dir=1.
- Timeout: right never answers.
  - Required: 40 clocks after the right trigger, erro_dir=1, medida_dir=4095, dir=0; the cycle still completes.
  - A pronto injected 3 clocks later has no effect.
- Simultaneous: left pronto on the exact final timeout clock with medida=3 → stored, esq=1, erro_esq=0.
- Overrun: left and right each answer after 39 clocks with INTERVALO=50 → next left trigger 1 clock after ESPERA entry; no medir pulses lost or doubled.
- Control: drop ligar during AGUARDA_DIR → INICIAL next clock, db_estado=0, prior outputs held.
  - Reset asserted mid-AGUARDA_ESQ clears all outputs to 0 on that edge.
